// File: rtl/alu_datapath_mc.sv
// Register file + operand mux + ALU with an issue/done handshake and registered results.
// Define MUL_ITER_EN to build in the iterative shift-add multiplier (ALUctrl=111).
module alu_datapath_mc #(
    parameter int NumberOfReg   = 32,
    parameter int Address_Width = 5,
    parameter int Data_Width    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     ready,
    input  logic [Address_Width-1:0] rs1,
    input  logic [Address_Width-1:0] rs2,
    input  logic [Address_Width-1:0] rd,
    input  logic                     en,
    input  logic                     ALUsrc,
    input  logic [Data_Width-1:0]    ImmOp,
    input  logic [2:0]               ALUctrl,
    output logic                     done,
    output logic [Data_Width-1:0]    ALUout,
    output logic                     eq,
    output logic [Data_Width-1:0]    a0
);

    localparam int ShW = $clog2(Data_Width);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [Data_Width-1:0]        regs [NumberOfReg];
    logic signed [Data_Width-1:0] op1;
    logic signed [Data_Width-1:0] op2;
    logic signed [Data_Width-1:0] alu_res;
    logic                         issue;
    logic                         is_mul;
    logic                         res_upd;
    logic                         wb_en;
    logic [Address_Width-1:0]     wb_addr;
    logic [Data_Width-1:0]        wb_data;

    assign issue  = start && ready;
    assign is_mul = (ALUctrl == OP_MUL);

    // x0 is hardwired to zero on the read side as well as never being written
    assign op1 = (rs1 == '0) ? '0 : regs[rs1];
    assign op2 = ALUsrc ? ImmOp : ((rs2 == '0) ? '0 : regs[rs2]);
    assign a0  = regs[10];

    always_comb begin
        alu_res = '0;
        case (ALUctrl)
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_SLT:  alu_res[0] = (op1 < op2);
            OP_SLL:  alu_res = op1 << op2[ShW-1:0];
            default: alu_res = '0;
        endcase
    end

`ifdef MUL_ITER_EN
    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ShW-1:0]           cnt;
    logic [Address_Width-1:0] rd_q;
    logic                     en_q;
    logic                     mul_last;
    logic [Data_Width-1:0]    acc;
    logic [Data_Width-1:0]    mcand;
    logic [Data_Width-1:0]    mplr;
    logic [Data_Width-1:0]    acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue && is_mul) state_nxt = S_MUL;
            S_MUL:   if (mul_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE);
    end

    assign mul_last = (state == S_MUL) && (cnt == ShW'(Data_Width - 1));
    assign acc_nxt  = acc + (mplr[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            rd_q <= '0;
            en_q <= 1'b0;
        end else if (issue && is_mul) begin
            cnt  <= '0;
            rd_q <= rd;
            en_q <= en;
        end else if (state == S_MUL) begin
            cnt <= cnt + 1'b1;
        end
    end

    // one shift-add step per cycle; the last step's sum goes straight to writeback
    always_ff @(posedge clk) begin
        if (issue && is_mul) begin
            acc   <= '0;
            mcand <= op1;
            mplr  <= op2;
        end else if (state == S_MUL) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
        end
    end

    assign res_upd = (issue && !is_mul) || mul_last;
    assign wb_en   = (issue && !is_mul && en) || (mul_last && en_q);
    assign wb_addr = mul_last ? rd_q : rd;
    assign wb_data = mul_last ? acc_nxt : alu_res;
`else
    // without the multiplier, ALUctrl=111 completes in one cycle with a zero result and no write
    assign ready   = 1'b1;
    assign res_upd = issue;
    assign wb_en   = issue && !is_mul && en;
    assign wb_addr = rd;
    assign wb_data = alu_res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumberOfReg; i++) regs[i] <= '0;
            ALUout <= '0;
            eq     <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= res_upd;
            if (issue) eq <= (op1 == op2);
            if (res_upd) ALUout <= wb_data;
            if (wb_en && (wb_addr != '0)) regs[wb_addr] <= wb_data;
        end
    end

endmodule
